// File: rtl/scratch_pad_pkg.sv
// rtl/scratch_pad_pkg.sv - shared widths and encodings for the scratch-pad arbiter
package scratch_pad_pkg;

    localparam int SP_DATA_W = 32;
    localparam int SP_BE_W   = 4;
    localparam int SP_AW     = 16;

    // An all-zero byte-enable vector marks a read access.
    localparam logic [SP_BE_W-1:0] SP_WEN_READ = '0;

    typedef logic [SP_BE_W-1:0]   sp_be_t;
    typedef logic [SP_DATA_W-1:0] sp_data_t;

    function automatic logic sp_is_read(input sp_be_t wen);
        return wen == SP_WEN_READ;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         HCLK,
    input  logic         HRESET,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scratch_pad_arbiter.sv
// rtl/scratch_pad_arbiter.sv - bus/engine arbiter for one single-port scratch-pad SRAM
module scratch_pad_arbiter
    import scratch_pad_pkg::*;
#(
    parameter int AW       = SP_AW,
    parameter int MAX_WAIT = 4,
    parameter int CW       = 16
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          bus_en,
    input  sp_be_t        bus_wen,
    input  logic [AW-1:0] bus_addr,
    input  sp_data_t      bus_wdata,
    output sp_data_t      bus_rdata,
    output logic          bus_ready,
    input  logic          eng_req,
    input  sp_be_t        eng_wen,
    input  logic [AW-1:0] eng_addr,
    input  sp_data_t      eng_wdata,
    output logic          eng_gnt,
    output logic          eng_rvalid,
    output sp_data_t      eng_rdata,
    output logic          mem_en,
    output sp_be_t        mem_wen,
    output logic [AW-1:0] mem_addr,
    output sp_data_t      mem_wdata,
    input  sp_data_t      mem_rdata,
    output logic [CW-1:0] conflict_cnt
);

    localparam int SW = 4;

    logic [SW-1:0] starve_cnt;
    logic          force_gnt;
    logic          bus_take;
    logic          rd_eng;

    // The bus wins unless the engine has lost MAX_WAIT times in a row.
    assign force_gnt = (starve_cnt == SW'(MAX_WAIT));
    assign eng_gnt   = eng_req & (~bus_en | force_gnt);
    assign bus_take  = bus_en & ~eng_gnt;
    assign bus_ready = ~(bus_en & eng_gnt);

    assign mem_en    = bus_take | eng_gnt;
    assign mem_wen   = eng_gnt ? eng_wen : (bus_take ? bus_wen : SP_WEN_READ);
    assign mem_addr  = eng_gnt ? eng_addr  : bus_addr;
    assign mem_wdata = eng_gnt ? eng_wdata : bus_wdata;

    sat_counter #(
        .W   (SW),
        .MAX (SW'(MAX_WAIT))
    ) u_starve (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .inc    (eng_req & bus_take),
        .clr    (eng_gnt | ~eng_req),
        .cnt    (starve_cnt)
    );

    sat_counter #(
        .W   (CW),
        .MAX ({CW{1'b1}})
    ) u_conflict (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .inc    (bus_en & eng_req),
        .clr    (1'b0),
        .cnt    (conflict_cnt)
    );

    // Owner tag for the word coming back next cycle; the bus side needs none.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rd_eng <= 1'b0;
        end else begin
            rd_eng <= eng_gnt & sp_is_read(eng_wen);
        end
    end

    assign eng_rvalid = rd_eng;
    assign eng_rdata  = rd_eng ? mem_rdata : '0;
    assign bus_rdata  = mem_rdata;

endmodule

// File: tb/tb_scratch_pad_arbiter.sv
// tb/tb_scratch_pad_arbiter.sv - directed vector bench for scratch_pad_arbiter
module tb_scratch_pad_arbiter;

    localparam int AW = 16;
    localparam int CW = 4;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          bus_en;
    logic [3:0]    bus_wen;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata;
    logic          bus_ready;
    logic          eng_req;
    logic [3:0]    eng_wen;
    logic [AW-1:0] eng_addr;
    logic [31:0]   eng_wdata;
    logic          eng_gnt;
    logic          eng_rvalid;
    logic [31:0]   eng_rdata;
    logic          mem_en;
    logic [3:0]    mem_wen;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [CW-1:0] conflict_cnt;

    always #5 HCLK = ~HCLK;

    scratch_pad_arbiter #(.AW(AW), .MAX_WAIT(4), .CW(CW)) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .bus_en       (bus_en),
        .bus_wen      (bus_wen),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ready    (bus_ready),
        .eng_req      (eng_req),
        .eng_wen      (eng_wen),
        .eng_addr     (eng_addr),
        .eng_wdata    (eng_wdata),
        .eng_gnt      (eng_gnt),
        .eng_rvalid   (eng_rvalid),
        .eng_rdata    (eng_rdata),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    typedef struct {
        logic          be;
        logic [3:0]    bwen;
        logic [AW-1:0] baddr;
        logic [31:0]   bwd;
        logic          er;
        logic [3:0]    ewen;
        logic [AW-1:0] eaddr;
        logic [31:0]   ewd;
        logic [31:0]   mrd;
        logic          x_rdy;
        logic          x_gnt;
        logic          x_rv;
        logic [31:0]   x_erd;
        logic          x_men;
        logic [3:0]    x_mwen;
        logic [AW-1:0] x_maddr;
        logic [31:0]   x_mwd;
        logic [CW-1:0] x_cc;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic be, input logic [3:0] bwen, input logic [AW-1:0] baddr, input logic [31:0] bwd,
        input logic er, input logic [3:0] ewen, input logic [AW-1:0] eaddr, input logic [31:0] ewd,
        input logic [31:0] mrd,
        input logic x_rdy, input logic x_gnt, input logic x_rv, input logic [31:0] x_erd,
        input logic x_men, input logic [3:0] x_mwen, input logic [AW-1:0] x_maddr,
        input logic [31:0] x_mwd, input logic [CW-1:0] x_cc);
        vec_t v;
        v.be = be; v.bwen = bwen; v.baddr = baddr; v.bwd = bwd;
        v.er = er; v.ewen = ewen; v.eaddr = eaddr; v.ewd = ewd; v.mrd = mrd;
        v.x_rdy = x_rdy; v.x_gnt = x_gnt; v.x_rv = x_rv; v.x_erd = x_erd;
        v.x_men = x_men; v.x_mwen = x_mwen; v.x_maddr = x_maddr; v.x_mwd = x_mwd; v.x_cc = x_cc;
        return v;
    endfunction

    task automatic drive(input logic be, input logic [3:0] bwen, input logic [AW-1:0] baddr,
                         input logic er, input logic [3:0] ewen, input logic [AW-1:0] eaddr);
        bus_en = be; bus_wen = bwen; bus_addr = baddr; bus_wdata = 32'h0;
        eng_req = er; eng_wen = ewen; eng_addr = eaddr; eng_wdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic pulse_reset();
        HRESET = 1'b1;
        #2;
        HRESET = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1;
        drive(0, 4'h0, '0, 0, 4'h0, '0);
        mem_rdata = 32'h0;

        // inputs: be bwen baddr bwd | er ewen eaddr ewd | mrd || rdy gnt rv erd | men mwen maddr mwd | cc
        vecs.push_back(mk(0,4'h0,16'h0000,32'h0,        0,4'h0,16'h0000,32'h0,        32'h0,        1,0,0,32'h0,        0,4'h0,16'h0000,32'h0,        0));
        vecs.push_back(mk(0,4'h0,16'h0000,32'h0,        1,4'h0,16'h0010,32'h0,        32'h0,        1,1,0,32'h0,        1,4'h0,16'h0010,32'h0,        0));
        vecs.push_back(mk(0,4'h0,16'h0000,32'h0,        0,4'h0,16'h0000,32'h0,        32'hDEADBEEF, 1,0,1,32'hDEADBEEF, 0,4'h0,16'h0000,32'h0,        0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1,4'hF,16'h0004,32'h12345678, 1,4'h0,16'h0020,32'h99, 32'h0,      1,0,0,32'h0,        1,4'hF,16'h0004,32'h12345678, 4'(k)));
        vecs.push_back(mk(1,4'hF,16'h0004,32'h12345678, 1,4'h0,16'h0020,32'h99,       32'h0,        0,1,0,32'h0,        1,4'h0,16'h0020,32'h99,       4));
        vecs.push_back(mk(1,4'hF,16'h0004,32'h12345678, 1,4'h0,16'h0020,32'h99,       32'hCAFEF00D, 1,0,1,32'hCAFEF00D, 1,4'hF,16'h0004,32'h12345678, 5));
        vecs.push_back(mk(0,4'h0,16'h0000,32'h0,        0,4'h0,16'h0000,32'h0,        32'h0,        1,0,0,32'h0,        0,4'h0,16'h0000,32'h0,        6));
        vecs.push_back(mk(1,4'h2,16'h0ABC,32'hA5A55A5A, 0,4'h0,16'h0000,32'h0,        32'h0,        1,0,0,32'h0,        1,4'h2,16'h0ABC,32'hA5A55A5A, 6));
        vecs.push_back(mk(0,4'h0,16'h0000,32'h0,        1,4'hC,16'h0033,32'h11223344, 32'h0,        1,1,0,32'h0,        1,4'hC,16'h0033,32'h11223344, 6));
        vecs.push_back(mk(0,4'h0,16'h0000,32'h0,        0,4'h0,16'h0000,32'h0,        32'h55555555, 1,0,0,32'h0,        0,4'h0,16'h0000,32'h0,        6));
        vecs.push_back(mk(1,4'h0,16'h0007,32'hFFFF0000, 0,4'h0,16'h0000,32'h0,        32'h0,        1,0,0,32'h0,        1,4'h0,16'h0007,32'hFFFF0000, 6));
        vecs.push_back(mk(0,4'h0,16'h0000,32'h0,        0,4'h0,16'h0000,32'h0,        32'h00000077, 1,0,0,32'h0,        0,4'h0,16'h0000,32'h0,        6));
        vecs.push_back(mk(1,4'h0,16'h0008,32'h0,        1,4'h0,16'h0009,32'h0,        32'h0,        1,0,0,32'h0,        1,4'h0,16'h0008,32'h0,        6));
        vecs.push_back(mk(0,4'h0,16'h0000,32'h0,        0,4'h0,16'h0000,32'h0,        32'h00001234, 1,0,0,32'h0,        0,4'h0,16'h0000,32'h0,        7));

        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        foreach (vecs[i]) begin
            bus_en = vecs[i].be; bus_wen = vecs[i].bwen; bus_addr = vecs[i].baddr; bus_wdata = vecs[i].bwd;
            eng_req = vecs[i].er; eng_wen = vecs[i].ewen; eng_addr = vecs[i].eaddr; eng_wdata = vecs[i].ewd;
            mem_rdata = vecs[i].mrd;
            @(negedge HCLK);
            chk($sformatf("v%0d bus_ready", i),    32'(bus_ready),    32'(vecs[i].x_rdy));
            chk($sformatf("v%0d eng_gnt", i),      32'(eng_gnt),      32'(vecs[i].x_gnt));
            chk($sformatf("v%0d eng_rvalid", i),   32'(eng_rvalid),   32'(vecs[i].x_rv));
            chk($sformatf("v%0d eng_rdata", i),    eng_rdata,         vecs[i].x_erd);
            chk($sformatf("v%0d bus_rdata", i),    bus_rdata,         vecs[i].mrd);
            chk($sformatf("v%0d mem_en", i),       32'(mem_en),       32'(vecs[i].x_men));
            chk($sformatf("v%0d mem_wen", i),      32'(mem_wen),      32'(vecs[i].x_mwen));
            chk($sformatf("v%0d mem_addr", i),     32'(mem_addr),     32'(vecs[i].x_maddr));
            chk($sformatf("v%0d mem_wdata", i),    mem_wdata,         vecs[i].x_mwd);
            chk($sformatf("v%0d conflict_cnt", i), 32'(conflict_cnt), 32'(vecs[i].x_cc));
            next_cycle();
        end

        // Reset arriving while an engine read is in flight.
        drive(0, 4'h0, '0, 1, 4'h0, 16'h0040);
        mem_rdata = 32'h0;
        @(negedge HCLK);
        chk("rst_inflight gnt", 32'(eng_gnt), 32'h1);
        next_cycle();
        eng_req = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        #1;
        chk("rst_inflight rvalid_before", 32'(eng_rvalid), 32'h1);
        HRESET = 1'b1;
        eng_req = 1'b1;
        #1;
        chk("rst_inflight rvalid", 32'(eng_rvalid), 32'h0);
        chk("rst_inflight rdata", eng_rdata, 32'h0);
        chk("rst_inflight cc", 32'(conflict_cnt), 32'h0);
        chk("rst_inflight comb_gnt", 32'(eng_gnt), 32'h1);
        chk("rst_inflight comb_mem_en", 32'(mem_en), 32'h1);
        eng_req = 1'b0;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_after rvalid", 32'(eng_rvalid), 32'h0);
        next_cycle();

        // Starvation count built up before reset must not survive it.
        drive(1, 4'h0, 16'h0001, 1, 4'h0, 16'h0002);
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            chk($sformatf("pre_rst conflict%0d gnt", k), 32'(eng_gnt), 32'h0);
            next_cycle();
        end
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge HCLK);
            chk($sformatf("post_rst conflict%0d gnt", k), 32'(eng_gnt), (k == 4) ? 32'h1 : 32'h0);
            chk($sformatf("post_rst conflict%0d ready", k), 32'(bus_ready), (k == 4) ? 32'h0 : 32'h1);
            next_cycle();
        end

        // Conflict counter saturation with a 4-bit counter.
        pulse_reset();
        for (int k = 0; k < 22; k++) begin
            @(negedge HCLK);
            chk($sformatf("sat cycle%0d cc", k), 32'(conflict_cnt), (k > 15) ? 32'd15 : 32'(k));
            next_cycle();
        end

        drive(0, 4'h0, '0, 0, 4'h0, '0);
        @(negedge HCLK);
        chk("sat hold cc", 32'(conflict_cnt), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
